// File: rtl/piso_frame_tx_pkg.sv
// Shared framing constants, FSM encoding and frame-length helper for the
// serial framer and the downstream deserializer bench.
package piso_frame_tx_pkg;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;
  localparam int   DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // Total clk cycles one frame occupies on the line.
  function automatic int frame_len(input int clks_per_bit, input int parity_en,
                                   input int stop_bits);
    return (1 + DATA_BITS + parity_en + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/piso_frame_tx_bit_timer.sv
// Bit-period timer: one-cycle bit_tick every CLKS_PER_BIT cycles.
// restart zeroes the count so the following bit gets a full period.
// With CLKS_PER_BIT=1 the count never leaves 0 and bit_tick is constant 1.
module piso_frame_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic bit_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  assign bit_tick = (count == LAST);

  // Free-running count that wraps on the tick and reloads on restart.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    count <= '0;
    else if (restart || bit_tick) count <= '0;
    else                          count <= count + CW'(1);
  end

endmodule

// File: rtl/piso_frame_tx.sv
// Serial framer: start bit 0, 8 data bits LSB first, optional even parity,
// STOP_BITS stop bits of 1; line idles high.
//
// Handshake: a byte is taken when data_valid && ready at a rising clk edge.
// ready is high in IDLE and on the final cycle of the last stop bit, so a
// source holding data_valid gets frames back to back with no idle gap. While
// ready is low data_valid is ignored and the source must hold its byte.
module piso_frame_tx #(
  parameter int CLKS_PER_BIT = 1,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       ready,
  output logic       serial_out,
  output logic       busy,
  output logic       frame_done
);

  import piso_frame_tx_pkg::*;

  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic       STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic       PAR_ON    = (PARITY_EN != 0);

  tx_state_t  state, state_next;
  logic [7:0] shift;
  logic       parity_bit;
  logic [2:0] bit_cnt;
  logic       stop_cnt;
  logic       bit_tick;
  logic       accept;
  logic       last_stop;

  assign last_stop = (state == ST_STOP) && bit_tick && (stop_cnt == STOP_LAST);
  assign accept    = data_valid && ready;

  piso_frame_tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk      (clk),
    .reset    (reset),
    .restart  (accept),
    .bit_tick (bit_tick)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic: each bit lasts one bit time, advanced by bit_tick.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (accept) state_next = ST_START;
      ST_START:  if (bit_tick) state_next = ST_DATA;
      ST_DATA:   if (bit_tick && (bit_cnt == LAST_DATA))
                   state_next = PAR_ON ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_tick) state_next = ST_STOP;
      ST_STOP:   if (last_stop) state_next = accept ? ST_START : ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; serial_out follows reset immediately.
  always_comb begin
    serial_out = IDLE_LVL;
    busy       = 1'b1;
    ready      = 1'b0;
    frame_done = 1'b0;
    case (state)
      ST_IDLE: begin
        busy  = 1'b0;
        ready = 1'b1;
      end
      ST_START:  serial_out = START_LVL;
      ST_DATA:   serial_out = shift[0];
      ST_PARITY: serial_out = parity_bit;
      ST_STOP: begin
        serial_out = STOP_LVL;
        ready      = last_stop;
        frame_done = last_stop;
      end
      default: begin
        busy  = 1'b0;
        ready = 1'b1;
      end
    endcase
  end

  // Byte capture, data shifting and bit/stop counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift      <= '0;
      parity_bit <= 1'b0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
    end else if (accept) begin
      shift      <= data_in;
      parity_bit <= ^data_in;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
    end else begin
      if ((state == ST_DATA) && bit_tick) begin
        shift   <= {1'b0, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if ((state == ST_STOP) && bit_tick) stop_cnt <= last_stop ? 1'b0 : 1'b1;
    end
  end

endmodule
